// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions: select codes, per-format field masks,
// and the field-placement helper (inverse of the core's immediate decode).
// Optional feature macro: IMM_ENC_CSR_EN (enables the C/zimm format).
package imm_encoder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] IMM_SEL_I = 3'b000;
  localparam logic [SEL_W-1:0] IMM_SEL_S = 3'b001;
  localparam logic [SEL_W-1:0] IMM_SEL_B = 3'b010;
  localparam logic [SEL_W-1:0] IMM_SEL_J = 3'b011;
  localparam logic [SEL_W-1:0] IMM_SEL_U = 3'b100;
  localparam logic [SEL_W-1:0] IMM_SEL_C = 3'b101;

  localparam logic [XLEN-1:0] IMM_MASK_I = 32'hFFF0_0000;
  localparam logic [XLEN-1:0] IMM_MASK_S = 32'hFE00_0F80;
  localparam logic [XLEN-1:0] IMM_MASK_B = 32'hFE00_0F80;
  localparam logic [XLEN-1:0] IMM_MASK_J = 32'hFFFF_F000;
  localparam logic [XLEN-1:0] IMM_MASK_U = 32'hFFFF_F000;
  localparam logic [XLEN-1:0] IMM_MASK_C = 32'h000F_8000;

  // Payload held in the first pipeline stage
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  imm;
    logic             err;
  } s1_word_t;

  // Immediate-field mask for a format; invalid formats touch no bits
  function automatic logic [XLEN-1:0] imm_mask(input logic [SEL_W-1:0] sel);
    logic [XLEN-1:0] m;
    m = '0;
    case (sel)
      IMM_SEL_I: m = IMM_MASK_I;
      IMM_SEL_S: m = IMM_MASK_S;
      IMM_SEL_B: m = IMM_MASK_B;
      IMM_SEL_J: m = IMM_MASK_J;
      IMM_SEL_U: m = IMM_MASK_U;
`ifdef IMM_ENC_CSR_EN
      IMM_SEL_C: m = IMM_MASK_C;
`endif
      default:   m = '0;
    endcase
    return m;
  endfunction

  // Scatter the immediate into the instruction bit positions of a format
  function automatic logic [XLEN-1:0] imm_place(input logic [SEL_W-1:0] sel,
                                                input logic [XLEN-1:0]  imm);
    logic [XLEN-1:0] p;
    p = '0;
    case (sel)
      IMM_SEL_I: p[31:20] = imm[11:0];
      IMM_SEL_S: begin
        p[31:25] = imm[11:5];
        p[11:7]  = imm[4:0];
      end
      IMM_SEL_B: begin
        p[31]    = imm[12];
        p[30:25] = imm[10:5];
        p[11:8]  = imm[4:1];
        p[7]     = imm[11];
      end
      IMM_SEL_J: begin
        p[31]    = imm[20];
        p[30:21] = imm[10:1];
        p[20]    = imm[11];
        p[19:12] = imm[19:12];
      end
      IMM_SEL_U: p[31:12] = imm[31:12];
`ifdef IMM_ENC_CSR_EN
      IMM_SEL_C: p[19:15] = imm[4:0];
`endif
      default:   p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Flags immediates the selected format cannot represent; invalid selects
// always flag. C format is only recognised when IMM_ENC_CSR_EN is defined.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [XLEN-1:0]  imm,
  output logic             err_c
);

  logic same_31_11;
  logic same_31_12;
  logic same_31_20;

  assign same_31_11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign same_31_12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign same_31_20 = (&imm[31:20]) | ~(|imm[31:20]);

  // Per-format representability check
  always_comb begin
    err_c = 1'b1;
    case (sel)
      IMM_SEL_I,
      IMM_SEL_S: err_c = ~same_31_11;
      IMM_SEL_B: err_c = ~same_31_12 | imm[0];
      IMM_SEL_J: err_c = ~same_31_20 | imm[0];
      IMM_SEL_U: err_c = |imm[11:0];
`ifdef IMM_ENC_CSR_EN
      IMM_SEL_C: err_c = |imm[31:5];
`endif
      default:   err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: merges an immediate into the
// immediate fields of a RISC-V instruction and flags unrepresentable values.
// Optional feature macro: IMM_ENC_CSR_EN (C/zimm format into rs1 field).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [XLEN-1:0]      in_base,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic     v1;
  logic     v2;
  s1_word_t s1;
  logic     s1_adv;
  logic     in_err;

  assign s1_adv    = ~v2 | out_ready;
  assign in_ready  = ~v1 | s1_adv;
  assign out_valid = v2;

  imm_range_check u_range (
    .sel   (in_sel),
    .imm   (in_imm),
    .err_c (in_err)
  );

  // Stage 1: capture request fields and range-check result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.sel  <= in_sel;
        s1.base <= in_base;
        s1.imm  <= in_imm;
        s1.err  <= in_err;
      end
    end
  end

  // Stage 2: merge immediate into base and hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      out_inst <= '0;
      out_err  <= 1'b0;
    end else if (s1_adv) begin
      v2 <= v1;
      if (v1) begin
        out_inst <= (s1.base & ~imm_mask(s1.sel)) | imm_place(s1.sel, s1.imm);
        out_err  <= s1.err;
      end
    end
  end

  // Saturating count of delivered error results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (v2 && out_ready && out_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
